// File: rtl/cnn_layer_accel_octo_input_loader_if.sv
// Stream bundle between the upstream word source, the input loader and the octo's tagged datain port.
// The master modport is the loader side; the slave modport is the source/octo side.
interface cnn_layer_accel_octo_input_loader_if #(
  parameter int unsigned C_DATA_WIDTH = 16
);
  logic [C_DATA_WIDTH-1:0] src_data;
  logic                    src_valid;
  logic                    src_rdy;
  logic                    seq_datain_tag;
  logic                    pixel_datain_tag;
  logic [C_DATA_WIDTH-1:0] datain;
  logic                    datain_valid;
  logic                    seq_datain_rdy;
  logic                    pixel_datain_rdy;

  modport master (
    input  src_data, src_valid, seq_datain_rdy, pixel_datain_rdy,
    output src_rdy, seq_datain_tag, pixel_datain_tag, datain, datain_valid
  );

  modport slave (
    output src_data, src_valid, seq_datain_rdy, pixel_datain_rdy,
    input  src_rdy, seq_datain_tag, pixel_datain_tag, datain, datain_valid
  );
endinterface

// File: rtl/cnn_layer_accel_octo_input_loader.sv
// Feeds cnn_layer_accel_octo: new_map pulse, then sequence words, a gap cycle, then pixel words.
// Optional CNN_LOADER_CHECKSUM_EN adds pixel_checksum (mod-2^32 sum of accepted pixel words).
module cnn_layer_accel_octo_input_loader #(
  parameter int unsigned C_DATA_WIDTH = 16,
  parameter int unsigned C_CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [C_CNT_WIDTH-1:0] seq_count_cfg,
  input  logic [C_CNT_WIDTH-1:0] pixel_count_cfg,
  cnn_layer_accel_octo_input_loader_if.master bus,
  output logic                   new_map,
  output logic                   busy,
  output logic                   done
`ifdef CNN_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]            pixel_checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAP,
    S_SEQ,
    S_GAP,
    S_PIX,
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [C_CNT_WIDTH-1:0]  seq_cnt_q;
  logic [C_CNT_WIDTH-1:0]  pix_cnt_q;
  logic [C_CNT_WIDTH-1:0]  issued_q;
  logic [C_CNT_WIDTH-1:0]  acc_q;
  logic [C_DATA_WIDTH-1:0] datain_q;
  logic                    valid_q;
  logic                    new_map_q;
  logic                    done_q;
`ifdef CNN_LOADER_CHECKSUM_EN
  logic [31:0]             checksum_q;
`endif

  logic [C_CNT_WIDTH-1:0]  count;
  logic                    accept;
  logic                    src_rdy;
  logic                    src_xfer;
  logic                    last_accept;

  // Compare one bit wider so a count of 2^C_CNT_WIDTH-1 never wraps the +1.
  always_comb begin
    count       = (state_q == S_SEQ) ? seq_cnt_q : pix_cnt_q;
    accept      = valid_q & (((state_q == S_SEQ) & bus.seq_datain_rdy) |
                             ((state_q == S_PIX) & bus.pixel_datain_rdy));
    src_rdy     = ((state_q == S_SEQ) | (state_q == S_PIX)) & (issued_q < count) &
                  (~valid_q | accept);
    src_xfer    = bus.src_valid & src_rdy;
    last_accept = accept &
                  (({1'b0, acc_q} + (C_CNT_WIDTH + 1)'(1)) == {1'b0, count});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      seq_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      issued_q   <= '0;
      acc_q      <= '0;
      datain_q   <= '0;
      valid_q    <= 1'b0;
      new_map_q  <= 1'b0;
      done_q     <= 1'b0;
`ifdef CNN_LOADER_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      new_map_q <= 1'b0;
      done_q    <= 1'b0;

      if (src_xfer) begin
        datain_q <= bus.src_data;
        valid_q  <= 1'b1;
        issued_q <= issued_q + 1'b1;
      end else if (accept) begin
        valid_q  <= 1'b0;
      end
      if (accept) begin
        acc_q <= acc_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            seq_cnt_q  <= seq_count_cfg;
            pix_cnt_q  <= pixel_count_cfg;
            new_map_q  <= 1'b1;
            state_q    <= S_MAP;
`ifdef CNN_LOADER_CHECKSUM_EN
            checksum_q <= '0;
`endif
          end
        end
        S_MAP: begin
          issued_q <= '0;
          acc_q    <= '0;
          state_q  <= (seq_cnt_q == '0) ? S_GAP : S_SEQ;
        end
        S_SEQ: begin
          if (last_accept) state_q <= S_GAP;
        end
        S_GAP: begin
          issued_q <= '0;
          acc_q    <= '0;
          if (pix_cnt_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_PIX;
          end
        end
        S_PIX: begin
`ifdef CNN_LOADER_CHECKSUM_EN
          if (accept) checksum_q <= checksum_q + 32'(datain_q);
`endif
          if (last_accept) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.src_rdy          = src_rdy;
  assign bus.datain           = datain_q;
  assign bus.datain_valid     = valid_q;
  assign bus.seq_datain_tag   = valid_q & (state_q == S_SEQ);
  assign bus.pixel_datain_tag = valid_q & (state_q == S_PIX);
  assign new_map              = new_map_q;
  assign done                 = done_q;
  assign busy                 = (state_q != S_IDLE);
`ifdef CNN_LOADER_CHECKSUM_EN
  assign pixel_checksum       = checksum_q;
`endif

endmodule

// File: tb/tb_cnn_layer_accel_octo_input_loader.sv
// Scoreboard bench for cnn_layer_accel_octo_input_loader: expected words queued at stimulus time,
// a negedge monitor pops and compares every accepted datain word.
module tb_cnn_layer_accel_octo_input_loader;
  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] seq_cfg;
  logic [CW-1:0] pix_cfg;
  logic          new_map;
  logic          busy;
  logic          done;
`ifdef CNN_LOADER_CHECKSUM_EN
  logic [31:0]   pixel_checksum;
`endif

  cnn_layer_accel_octo_input_loader_if #(.C_DATA_WIDTH(DW)) bus ();

  cnn_layer_accel_octo_input_loader #(
    .C_DATA_WIDTH(DW),
    .C_CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .seq_count_cfg  (seq_cfg),
    .pixel_count_cfg(pix_cfg),
    .bus            (bus.master),
    .new_map        (new_map),
    .busy           (busy),
    .done           (done)
`ifdef CNN_LOADER_CHECKSUM_EN
    ,
    .pixel_checksum (pixel_checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_pix;
    logic [DW-1:0] data;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] src_q[$];

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  int          src_mode = 0;
  int          pix_acc, seq_acc, newmap_cnt, done_cnt, done_cyc;
  int          hold_left;
  bit          hold_done;
  bit          mon_en = 1'b0;
  logic [31:0] exp_sum;
  logic [31:0] cks_at_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Source and ready driver: decide handshakes at negedge, change inputs just after posedge.
  initial begin
    bus.src_valid        = 1'b0;
    bus.src_data         = '0;
    bus.seq_datain_rdy   = 1'b0;
    bus.pixel_datain_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.src_valid && bus.src_rdy && src_q.size() > 0) void'(src_q.pop_front());
      @(posedge clk);
      #1;
      bus.src_valid = (src_q.size() > 0) && (src_mode == 0 || $urandom_range(3) != 0);
      bus.src_data  = (src_q.size() > 0) ? src_q[0] : DW'($urandom);
      case (rdy_mode)
        0: begin
          bus.seq_datain_rdy   = 1'b1;
          bus.pixel_datain_rdy = 1'b1;
        end
        1: begin
          bus.seq_datain_rdy = 1'b1;
          if (pix_acc == 43 && !hold_done) begin
            if (hold_left == 0) hold_left = 5;
            bus.pixel_datain_rdy = 1'b0;
            hold_left--;
            if (hold_left == 0) hold_done = 1'b1;
          end else begin
            bus.pixel_datain_rdy = ~bus.pixel_datain_rdy;
          end
        end
        default: begin
          bus.seq_datain_rdy   = $urandom_range(1) != 0;
          bus.pixel_datain_rdy = $urandom_range(1) != 0;
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted word and checks hold stability.
  initial begin
    logic          prev_held;
    logic [DW-1:0] prev_data;
    logic          prev_stag, prev_ptag;
    logic          acc;
    word_t         e;
    prev_held = 1'b0;
    prev_data = '0;
    prev_stag = 1'b0;
    prev_ptag = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (new_map) newmap_cnt++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
`ifdef CNN_LOADER_CHECKSUM_EN
          cks_at_done = pixel_checksum;
`endif
        end
        if (bus.datain_valid)
          check("tag_onehot", $countones({bus.seq_datain_tag, bus.pixel_datain_tag}), 1);
        if (prev_held) begin
          check("hold_data", bus.datain, prev_data);
          check("hold_tag", {bus.datain_valid, bus.seq_datain_tag, bus.pixel_datain_tag},
                {1'b1, prev_stag, prev_ptag});
        end
        acc = bus.datain_valid && ((bus.seq_datain_tag && bus.seq_datain_rdy) ||
                                   (bus.pixel_datain_tag && bus.pixel_datain_rdy));
        if (acc) begin
          if (exp_q.size() == 0) begin
            check("extra_word", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("word_tag", bus.pixel_datain_tag, e.is_pix);
            check("word_data", bus.datain, e.data);
            if (bus.pixel_datain_tag) pix_acc++;
            else seq_acc++;
          end
        end
        prev_held = bus.datain_valid && !acc;
        prev_data = bus.datain;
        prev_stag = bus.seq_datain_tag;
        prev_ptag = bus.pixel_datain_tag;
      end else begin
        prev_held = 1'b0;
      end
    end
  end

  task automatic prep(input int nseq, input int npix, input int rmode, input int smode,
                      input bit ramp);
    logic [DW-1:0] w;
    exp_q.delete();
    src_q.delete();
    rdy_mode   = rmode;
    src_mode   = smode;
    hold_done  = 1'b0;
    hold_left  = 0;
    pix_acc    = 0;
    seq_acc    = 0;
    newmap_cnt = 0;
    done_cnt   = 0;
    done_cyc   = -1;
    exp_sum    = '0;
    for (int i = 0; i < nseq; i++) begin
      w = DW'($urandom);
      src_q.push_back(w);
      exp_q.push_back('{1'b0, w});
    end
    for (int i = 0; i < npix; i++) begin
      w = ramp ? DW'(i + 1) : DW'($urandom);
      exp_sum = exp_sum + 32'(w);
      src_q.push_back(w);
      exp_q.push_back('{1'b1, w});
    end
  endtask

  task automatic launch(input int nseq, input int npix, output int sc);
    @(posedge clk);
    #1;
    seq_cfg = CW'(nseq);
    pix_cfg = CW'(npix);
    start   = 1'b1;
    sc      = cyc;
    @(posedge clk);
    #1;
    start   = 1'b0;
    seq_cfg = CW'($urandom);
    pix_cfg = CW'($urandom);
  endtask

  task automatic finish_load(input int nseq, input int npix, input int sc, input int exp_lat,
                             input bit restart_mid);
    int bound;
    bound = (nseq + npix) * 40 + 50;
    for (int i = 0; i < bound && done_cnt == 0; i++) begin
      @(posedge clk);
      #1;
      start = restart_mid && (i == 30);
    end
    start = 1'b0;
    check("done_seen", done_cnt, 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt, 1);
    check("new_map_once", newmap_cnt, 1);
    check("all_words_delivered", exp_q.size(), 0);
    check("idle_after_done", {busy, bus.src_rdy, bus.datain_valid}, 3'b000);
    if (exp_lat > 0) check("done_latency", done_cyc - sc, exp_lat);
`ifdef CNN_LOADER_CHECKSUM_EN
    check("checksum", cks_at_done, exp_sum);
`endif
  endtask

  task automatic run_load(input int nseq, input int npix, input int rmode, input int smode,
                          input bit ramp, input int exp_lat, input bit restart_mid);
    int sc;
    prep(nseq, npix, rmode, smode, ramp);
    launch(nseq, npix, sc);
    finish_load(nseq, npix, sc, exp_lat, restart_mid);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int ns, np;
    rst     = 1'b1;
    start   = 1'b0;
    seq_cfg = '0;
    pix_cfg = '0;
    repeat (2) @(posedge clk);
    #1;
    start   = 1'b1;
    seq_cfg = CW'(3);
    pix_cfg = CW'(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("reset_outputs", {new_map, busy, done, bus.datain, bus.datain_valid,
                            bus.seq_datain_tag, bus.pixel_datain_tag, bus.src_rdy}, '0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_outputs", {new_map, busy, done, bus.datain, bus.datain_valid,
                           bus.seq_datain_tag, bus.pixel_datain_tag, bus.src_rdy}, '0);

    // Full-rate load, then the stalling pixel pattern with a start pulse mid-load.
    run_load(40, 100, 0, 0, 1'b0, 145, 1'b0);
    run_load(40, 100, 1, 0, 1'b0, 0, 1'b1);
    run_load(0, 3, 0, 0, 1'b0, 7, 1'b0);
    check("no_seq_words", seq_acc, 0);
    run_load(0, 0, 0, 0, 1'b0, 3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      ns = $urandom_range(12);
      np = $urandom_range(20);
      run_load(ns, np, 2, 1, 1'b0, 0, 1'b0);
    end

    // Reset in the middle of the sequence phase, then a fresh load from word 0.
    prep(40, 10, 0, 0, 1'b0);
    launch(40, 10, sc);
    for (int i = 0; i < 500 && seq_acc < 20; i++) begin
      @(posedge clk);
      #1;
    end
    check("reached_seq_20", seq_acc >= 20, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {new_map, busy, done, bus.datain, bus.datain_valid,
                              bus.seq_datain_tag, bus.pixel_datain_tag, bus.src_rdy}, '0);
    run_load(40, 100, 0, 0, 1'b0, 145, 1'b0);

`ifdef CNN_LOADER_CHECKSUM_EN
    run_load(4, 100, 2, 1, 1'b1, 0, 1'b0);
    check("checksum_5050", cks_at_done, 32'd5050);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
